vga_pixel_streamer: RTL
=======================

Name: vga_pixel_streamer

Overview:
- Downstream consumer of the merge stage's ping-pong line buffers: R/G/B_outRegA and R/G/B_outRegB, each 128 bits holding 16 pixels of 8 bits per channel.
- Generates 640x480@60 VGA timing and serialises one buffer's 16 pixels onto the VGA RGB pins, one pixel per pixel tick.
- Drives readVgaSelector back to merge to swap buffers. Uses merge's stopMerge as the "write-side buffer full" indication.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz pixel rate); legal range 1..8.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- R_inA, G_inA, B_inA  in  128 each  buffer A, connected to merge R/G/B_outRegA.
- R_inB, G_inB, B_inB  in  128 each  buffer B, connected to merge R/G/B_outRegB.
- stopMerge  in  1  1 = buffer not currently selected for reading is full and readable.
- readVgaSelector  out  1  0 = streamer reads A (merge fills B); 1 = streamer reads B (merge fills A).
- R_vga, G_vga, B_vga  out  8 each  pixel colour.
- hsync, vsync  out  1 each  active-low sync.
- video_on  out  1  high during visible area.
- frame_start  out  1  one-clock pulse when the (0,0) pixel is presented.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset values: readVgaSelector=1; R/G/B_vga=0; hsync=vsync=1; video_on=0; frame_start=0; underflow=0; all counters 0; state=WAIT_FILL.
- Pixel tick: divider counts 0..CLK_DIV-1. pix_en is high for one clk when the divider equals CLK_DIV-1. All timing and stream state advances only on pix_en.
- hcnt runs 0..(H_ACTIVE+H_FP+H_SYNC+H_BP-1)=799, then wraps to 0 and increments vcnt.
- vcnt runs 0..524, then wraps to 0.
- Sync windows:
  - hsync is low for hcnt in [656,751].
  - vsync is low for vcnt in [490,491].
  - active = hcnt<640 and vcnt<480.
- Output latency: outputs are registered on pix_en and reflect the hcnt/vcnt value from before that tick, so there is a 1 pixel-tick latency. Sync, video_on and RGB are all aligned to each other.
- Pixel select: slot 0..15 selects bits [slot*8 +: 8] of the read buffer, slot 0 first. The read buffer is A when readVgaSelector=0 and B when it is 1.
- Outside active, RGB=0 and slot does not advance.
- State WAIT_FILL: timing runs, RGB=0. On a clk with stopMerge=1, toggle readVgaSelector to 0 and go to WAIT_FRAME.
- State WAIT_FRAME: RGB=0. On the pix_en where hcnt=0 and vcnt=0, go to STREAM. That pixel is already streamed, slot 0.
- State STREAM: on each active pix_en, output the pixel at slot, then slot++. When slot=15 is consumed:
  - If stopMerge=1 on the same clk: toggle readVgaSelector, slot<=0, stay in STREAM.
  - Else: go to UNDERRUN, slot<=0.
- State UNDERRUN: each active pixel outputs RGB=0 and sets underflow=1. On the first pix_en with stopMerge=1, toggle readVgaSelector and return to STREAM. The pixel on that tick is taken from the new buffer, slot 0.
- Selector changes only in the clk cycle of a swap. It never toggles twice within 16 pixel ticks.
- frame_start asserts together with the registered output of pixel (0,0), every frame, in any state.
- underflow is cleared only by reset.
- Reset mid-line: all outputs return to reset values asynchronously. After release the sequence restarts from WAIT_FILL; no partial-frame streaming occurs.

Test Plan:
- Reset release with stopMerge=0 for 1000 clks -> readVgaSelector stays 1; RGB=0; hsync low exactly at hcnt 656..751; line period 1600 clks at CLK_DIV=2.
- Buffer A R=0x0F0E..0100 (slot k=k), stopMerge=1 -> selector goes 0; at frame start R_vga sequence is 0x00,0x01..0x0F on consecutive pixel ticks; frame_start pulses once.
- stopMerge held 1, B R slots all 0xAA -> after pixel 15, selector toggles to 1 and pixel 16 is 0xAA; no gap; underflow stays 0.
- stopMerge=0 at slot-15 consume, raised 5 pixel ticks later -> 5 black pixels, underflow=1 (sticky), resume at slot 0 of new buffer.
- Frame counting: vsync low for exactly 2 lines (3200 clks) per 525-line frame; video_on high 640x480 ticks per frame.
- Assert reset mid-line during STREAM -> outputs zero within the same clk (async), selector=1; after release the block waits for stopMerge and frame start again.

Source files
------------

// File: rtl/vga_pixel_streamer.sv
// VGA timing generator that serialises 16-pixel ping-pong line buffers from the merge stage
// onto registered RGB/sync outputs, swapping buffers with readVgaSelector.
module vga_pixel_streamer #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] R_inA,
  input  logic [127:0] G_inA,
  input  logic [127:0] B_inA,
  input  logic [127:0] R_inB,
  input  logic [127:0] G_inB,
  input  logic [127:0] B_inB,
  input  logic         stopMerge,
  output logic         readVgaSelector,
  output logic [7:0]   R_vga,
  output logic [7:0]   G_vga,
  output logic [7:0]   B_vga,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         frame_start,
  output logic         underflow
);

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    WAIT_FILL  = 2'd0,
    WAIT_FRAME = 2'd1,
    STREAM     = 2'd2,
    UNDERRUN   = 2'd3
  } state_t;

  state_t       state_r, state_nxt_s;
  logic [3:0]   div_r;
  logic [11:0]  hcnt_r, vcnt_r;
  logic [3:0]   slot_r, slot_nxt_s;
  logic         sel_nxt_s, uf_nxt_s;
  logic [7:0]   r_nxt_s, g_nxt_s, b_nxt_s;
  logic         pix_en_s, active_s, origin_s;
  logic [127:0] cur_r_s, cur_g_s, cur_b_s;
  logic [127:0] alt_r_s, alt_g_s, alt_b_s;

  function automatic logic [7:0] pick(input logic [127:0] buf_v, input logic [3:0] slot_v);
    return buf_v[{slot_v, 3'b000} +: 8];
  endfunction

  assign pix_en_s = (div_r == DIV_LAST);
  assign active_s = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
  assign origin_s = (hcnt_r == 12'd0) && (vcnt_r == 12'd0);
  // "cur" is the buffer being read now; "alt" is the one a swap would switch to.
  assign cur_r_s  = readVgaSelector ? R_inB : R_inA;
  assign cur_g_s  = readVgaSelector ? G_inB : G_inA;
  assign cur_b_s  = readVgaSelector ? B_inB : B_inA;
  assign alt_r_s  = readVgaSelector ? R_inA : R_inB;
  assign alt_g_s  = readVgaSelector ? G_inA : G_inB;
  assign alt_b_s  = readVgaSelector ? B_inA : B_inB;

  // Pixel-tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= 4'd0;
    end else if (pix_en_s) begin
      div_r <= 4'd0;
    end else begin
      div_r <= div_r + 4'd1;
    end
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_r <= 12'd0;
      vcnt_r <= 12'd0;
    end else if (pix_en_s) begin
      if (hcnt_r == H_LAST) begin
        hcnt_r <= 12'd0;
        vcnt_r <= (vcnt_r == V_LAST) ? 12'd0 : vcnt_r + 12'd1;
      end else begin
        hcnt_r <= hcnt_r + 12'd1;
      end
    end
  end

  // Stream FSM next-state, slot, selector and pixel selection.
  always_comb begin
    state_nxt_s = state_r;
    slot_nxt_s  = slot_r;
    sel_nxt_s   = readVgaSelector;
    uf_nxt_s    = underflow;
    r_nxt_s     = 8'h00;
    g_nxt_s     = 8'h00;
    b_nxt_s     = 8'h00;
    case (state_r)
      WAIT_FILL: begin
        if (stopMerge) begin
          sel_nxt_s   = 1'b0;
          state_nxt_s = WAIT_FRAME;
        end else begin
          state_nxt_s = WAIT_FILL;
        end
      end
      WAIT_FRAME: begin
        // The origin pixel itself is already streamed from slot 0.
        if (pix_en_s && origin_s) begin
          state_nxt_s = STREAM;
          r_nxt_s     = pick(cur_r_s, 4'd0);
          g_nxt_s     = pick(cur_g_s, 4'd0);
          b_nxt_s     = pick(cur_b_s, 4'd0);
          slot_nxt_s  = 4'd1;
        end else begin
          state_nxt_s = WAIT_FRAME;
        end
      end
      STREAM: begin
        if (pix_en_s && active_s) begin
          r_nxt_s = pick(cur_r_s, slot_r);
          g_nxt_s = pick(cur_g_s, slot_r);
          b_nxt_s = pick(cur_b_s, slot_r);
          if (slot_r == 4'd15) begin
            slot_nxt_s = 4'd0;
            if (stopMerge) begin
              sel_nxt_s = ~readVgaSelector;
            end else begin
              state_nxt_s = UNDERRUN;
            end
          end else begin
            slot_nxt_s = slot_r + 4'd1;
          end
        end else begin
          slot_nxt_s = slot_r;
        end
      end
      UNDERRUN: begin
        if (pix_en_s) begin
          if (stopMerge) begin
            sel_nxt_s   = ~readVgaSelector;
            state_nxt_s = STREAM;
            if (active_s) begin
              r_nxt_s    = pick(alt_r_s, 4'd0);
              g_nxt_s    = pick(alt_g_s, 4'd0);
              b_nxt_s    = pick(alt_b_s, 4'd0);
              slot_nxt_s = 4'd1;
            end else begin
              slot_nxt_s = 4'd0;
            end
          end else if (active_s) begin
            uf_nxt_s = 1'b1;
          end else begin
            uf_nxt_s = underflow;
          end
        end else begin
          state_nxt_s = UNDERRUN;
        end
      end
      default: begin
        state_nxt_s = WAIT_FILL;
        slot_nxt_s  = 4'd0;
      end
    endcase
  end

  // FSM state, slot, selector and sticky underflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= WAIT_FILL;
      slot_r          <= 4'd0;
      readVgaSelector <= 1'b1;
      underflow       <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      slot_r          <= slot_nxt_s;
      readVgaSelector <= sel_nxt_s;
      underflow       <= uf_nxt_s;
    end
  end

  // Registered video outputs, all one pixel tick behind the raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R_vga       <= 8'h00;
      G_vga       <= 8'h00;
      B_vga       <= 8'h00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en_s && origin_s;
      if (pix_en_s) begin
        R_vga    <= r_nxt_s;
        G_vga    <= g_nxt_s;
        B_vga    <= b_nxt_s;
        hsync    <= !((hcnt_r >= HS_START) && (hcnt_r <= HS_END));
        vsync    <= !((vcnt_r >= VS_START) && (vcnt_r <= VS_END));
        video_on <= active_s;
      end
    end
  end

endmodule
